// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: per-cycle PC enable and latch ld/flush,
// plus a small FSM for interrupt drain/vector and halt.
module pipe_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ex_mem_read,
  input  logic [1:0] ex_rd,
  input  logic [1:0] id_ra,
  input  logic [1:0] id_rb,
  input  logic       id_use_ra,
  input  logic       id_use_rb,
  input  logic       ex_branch_taken,
  input  logic       mem_busy,
  input  logic       wb_hlt,
  input  logic       irq,
  output logic       pc_ld,
  output logic       pc_sel_int,
  output logic       if_id_ld,
  output logic       if_id_flush,
  output logic       id_ex_ld,
  output logic       id_ex_flush,
  output logic       ex_m_ld,
  output logic       ex_m_flush,
  output logic       m_wb_ld,
  output logic       m_wb_flush,
  output logic       irq_ack,
  output logic       halted
);
  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_VEC, S_HALT} state_e;

  // Latch vectors: [3]=IF/ID, [2]=ID/EX, [1]=EX/M, [0]=M/WB
  typedef struct packed {
    logic       pc_ld;
    logic       pc_sel_int;
    logic       irq_ack;
    logic       halted;
    logic [3:0] ld;
    logic [3:0] flush;
  } ctl_t;

  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] dcnt_q, dcnt_d;
  logic       irq_pend_q, irq_pend_d;
  logic       irq_q, irq_d;
  logic       lu, vec_taken;
  ctl_t       c, o;

  assign lu = ex_mem_read & ((id_use_ra & (id_ra == ex_rd)) |
                             (id_use_rb & (id_rb == ex_rd)));

  always_comb begin
    c          = '{pc_ld: 1'b1, pc_sel_int: 1'b0, irq_ack: 1'b0, halted: 1'b0,
                   ld: 4'hf, flush: 4'h0};
    state_d    = state_q;
    dcnt_d     = dcnt_q;
    vec_taken  = 1'b0;
    case (state_q)
      S_RUN: begin
        if (wb_hlt) begin
          c.flush = 4'hf;
          c.pc_ld = 1'b0;
          state_d = S_HALT;
        end else if (ex_branch_taken) begin
          c.flush[3] = 1'b1;
          c.flush[2] = 1'b1;
        end else if (lu) begin
          c.pc_ld    = 1'b0;
          c.ld[3]    = 1'b0;
          c.flush[2] = 1'b1;
        end else if (mem_busy) begin
          c.pc_ld    = 1'b0;
          c.flush[3] = 1'b1;
        end else if (irq_pend_q) begin
          c.pc_ld    = 1'b0;
          c.flush[3] = 1'b1;
          dcnt_d     = DRAIN_INIT;
          state_d    = (DRAIN_CYCLES == 1) ? S_VEC : S_DRAIN;
        end
      end
      S_DRAIN: begin
        c.pc_ld    = 1'b0;
        c.flush[3] = 1'b1;
        if (wb_hlt) begin
          c.flush = 4'hf;
          state_d = S_HALT;
        end else begin
          // a branch retargets the return address; neither it nor lu pauses the drain
          if (ex_branch_taken) begin
            c.pc_ld    = 1'b1;
            c.flush[2] = 1'b1;
          end
          if (lu) c.flush[2] = 1'b1;
          dcnt_d = dcnt_q - 3'd1;
          if (dcnt_q <= 3'd1) state_d = S_VEC;
        end
      end
      S_VEC: begin
        if (wb_hlt) begin
          c.flush = 4'hf;
          c.pc_ld = 1'b0;
          state_d = S_HALT;
        end else begin
          c.pc_sel_int = 1'b1;
          c.irq_ack    = 1'b1;
          c.flush[3]   = 1'b1;
          vec_taken    = 1'b1;
          state_d      = S_RUN;
        end
      end
      default: begin
        c.pc_ld  = 1'b0;
        c.ld     = 4'h0;
        c.halted = 1'b1;
      end
    endcase
  end

  assign irq_d      = irq;
  assign irq_pend_d = (irq & ~irq_q) | (irq_pend_q & ~vec_taken);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_RUN;
      dcnt_q     <= 3'd0;
      irq_pend_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      irq_pend_q <= irq_pend_d;
      irq_q      <= irq_d;
    end
  end

  // Outputs are quiet for as long as reset is held
  assign o = reset ? c : '0;

  assign pc_ld       = o.pc_ld;
  assign pc_sel_int  = o.pc_sel_int;
  assign irq_ack     = o.irq_ack;
  assign halted      = o.halted;
  assign if_id_ld    = o.ld[3];
  assign id_ex_ld    = o.ld[2];
  assign ex_m_ld     = o.ld[1];
  assign m_wb_ld     = o.ld[0];
  assign if_id_flush = o.flush[3];
  assign id_ex_flush = o.flush[2];
  assign ex_m_flush  = o.flush[1];
  assign m_wb_flush  = o.flush[0];
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (DRAIN_CYCLES=3); outputs packed as
// {pc_ld,pc_sel_int,irq_ack,halted, ld[IF/ID..M/WB], flush[IF/ID..M/WB]}.
module tb_pipe_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       ex_mem_read, id_use_ra, id_use_rb, ex_branch_taken, mem_busy, wb_hlt, irq;
  logic [1:0] ex_rd, id_ra, id_rb;
  logic       pc_ld, pc_sel_int, if_id_ld, if_id_flush, id_ex_ld, id_ex_flush;
  logic       ex_m_ld, ex_m_flush, m_wb_ld, m_wb_flush, irq_ack, halted;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.DRAIN_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .id_ra(id_ra), .id_rb(id_rb), .id_use_ra(id_use_ra), .id_use_rb(id_use_rb),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy), .wb_hlt(wb_hlt), .irq(irq),
    .pc_ld(pc_ld), .pc_sel_int(pc_sel_int), .if_id_ld(if_id_ld), .if_id_flush(if_id_flush),
    .id_ex_ld(id_ex_ld), .id_ex_flush(id_ex_flush), .ex_m_ld(ex_m_ld), .ex_m_flush(ex_m_flush),
    .m_wb_ld(m_wb_ld), .m_wb_flush(m_wb_flush), .irq_ack(irq_ack), .halted(halted)
  );

  wire [11:0] obs = {pc_ld, pc_sel_int, irq_ack, halted,
                     if_id_ld, id_ex_ld, ex_m_ld, m_wb_ld,
                     if_id_flush, id_ex_flush, ex_m_flush, m_wb_flush};

  function automatic logic [11:0] ex(input logic pc, input logic sel, input logic ack,
                                     input logic hl, input logic [3:0] ld, input logic [3:0] fl);
    return {pc, sel, ack, hl, ld, fl};
  endfunction

  localparam logic [11:0] DEF  = 12'b1000_1111_0000;
  localparam logic [11:0] ZERO = 12'b0000_0000_0000;
  localparam logic [11:0] HLTD = 12'b0001_0000_0000;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic clr();
    ex_mem_read = 0; ex_rd = 0; id_ra = 0; id_rb = 0; id_use_ra = 0; id_use_rb = 0;
    ex_branch_taken = 0; mem_busy = 0; wb_hlt = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_lu();
    ex_mem_read = 1; ex_rd = 2; id_ra = 2; id_use_ra = 1;
  endtask

  initial begin
    reset = 0; irq = 0; clr();
    #12 chk("reset_hold", obs, ZERO);
    @(negedge clk) reset = 1;
    tick(); chk("rst_release", obs, DEF);

    // load-use via ra, then via rb, then a non-hazard lookalike
    set_lu(); #1 chk("lu_ra", obs, ex(0,0,0,0,4'b0111,4'b0100));
    tick(); clr(); ex_mem_read = 1; ex_rd = 3; id_rb = 3; id_use_rb = 1; id_ra = 1; id_use_ra = 1;
    #1 chk("lu_rb", obs, ex(0,0,0,0,4'b0111,4'b0100));
    tick(); clr(); ex_mem_read = 1; ex_rd = 2; id_ra = 2; id_use_ra = 0;
    #1 chk("lu_unused", obs, DEF);
    tick(); clr(); #1 chk("lu_clear", obs, DEF);

    // branch beats load-use and mem_busy
    tick(); set_lu(); ex_branch_taken = 1; mem_busy = 1;
    #1 chk("br_prio", obs, ex(1,0,0,0,4'b1111,4'b1100));
    // load-use beats mem_busy
    tick(); clr(); set_lu(); mem_busy = 1;
    #1 chk("lu_over_busy", obs, ex(0,0,0,0,4'b0111,4'b0100));

    // structural stall, two cycles
    tick(); clr(); mem_busy = 1; #1 chk("busy1", obs, ex(0,0,0,0,4'b1111,4'b1000));
    tick(); #1 chk("busy2", obs, ex(0,0,0,0,4'b1111,4'b1000));
    tick(); clr(); #1 chk("busy_clear", obs, DEF);

    // interrupt: rise, RUN entry, 2 DRAIN (lu then branch, neither extends), VEC
    tick(); irq = 1; #1 chk("irq_rise", obs, DEF);
    tick(); #1 chk("irq_entry", obs, ex(0,0,0,0,4'b1111,4'b1000));
    tick(); set_lu(); #1 chk("drain_lu", obs, ex(0,0,0,0,4'b1111,4'b1100));
    tick(); clr(); ex_branch_taken = 1; #1 chk("drain_br", obs, ex(1,0,0,0,4'b1111,4'b1100));
    tick(); clr(); #1 chk("vec", obs, ex(1,1,1,0,4'b1111,4'b1000));
    for (int i = 0; i < 4; i++) begin
      tick(); #1 chk("no_reack", obs, DEF);
    end
    irq = 0;

    // halt from RUN, persists even with a branch present
    tick(); wb_hlt = 1; #1 chk("hlt_run", obs, ex(0,0,0,0,4'b1111,4'b1111));
    tick(); wb_hlt = 0; ex_branch_taken = 1; #1 chk("halted1", obs, HLTD);
    tick(); #1 chk("halted2", obs, HLTD);
    tick(); irq = 1; #1 chk("halted_irq", obs, HLTD);
    tick(); irq = 0; reset = 0; #1 chk("hlt_rst", obs, ZERO);
    #2 reset = 1; ex_branch_taken = 0; #1 chk("hlt_exit", obs, DEF);

    // halt from DRAIN
    tick(); irq = 1; #1 chk("irq2_rise", obs, DEF);
    tick(); #1 chk("irq2_entry", obs, ex(0,0,0,0,4'b1111,4'b1000));
    tick(); wb_hlt = 1; #1 chk("hlt_drain", obs, ex(0,0,0,0,4'b1111,4'b1111));
    tick(); wb_hlt = 0; #1 chk("halted3", obs, HLTD);
    tick(); irq = 0; reset = 0; #1 chk("hlt_rst2", obs, ZERO);
    #2 reset = 1; #1 chk("hlt_exit2", obs, DEF);

    // asynchronous reset mid-DRAIN drops the pending interrupt
    tick(); irq = 1; #1 chk("irq3_rise", obs, DEF);
    tick(); #1 chk("irq3_entry", obs, ex(0,0,0,0,4'b1111,4'b1000));
    tick(); #1 chk("irq3_drain", obs, ex(0,0,0,0,4'b1111,4'b1000));
    #1 reset = 0; #1 chk("rst_async", obs, ZERO);
    irq = 0;
    tick(); chk("rst_held", obs, ZERO);
    @(negedge clk) reset = 1;
    for (int i = 0; i < 5; i++) begin
      tick(); #1 chk("post_rst", obs, DEF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
